mul: RTL and testbench
======================

MUL -- requirements
Module: mul

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits; product width 2*WIDTH.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, request to begin a multiply; sampled on rising clk.
REQ-005 SHALL have port a, input, WIDTH, multiplicand, two's-complement signed.
REQ-006 SHALL have port b, input, WIDTH, multiplier, two's-complement signed.
REQ-007 SHALL have port busy, output, 1, high while a multiply is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking a new valid result on y.
REQ-009 SHALL have port y, output, 2*WIDTH, signed product a*b, registered.

Function
REQ-010 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-011 In IDLE with start=1 at a rising edge, SHALL capture a and b, clear the step counter and enter RUN; busy=1 from that edge.
REQ-012 In IDLE with start=0, SHALL remain in IDLE with busy=0 and done=0.
REQ-013 In RUN, SHALL perform one radix-2 Booth step (add/sub multiplicand per multiplier bit pair, arithmetic shift right) per cycle, exactly WIDTH steps.
REQ-014 Accumulator SHALL carry one guard bit so the most negative operand (-2^(WIDTH-1)) is handled exactly.
REQ-015 After step WIDTH (edge k+WIDTH when start is accepted at edge k), SHALL load y with the full 2*WIDTH-bit signed product, set done=1, clear busy, and enter DONE.
REQ-016 In DONE, SHALL return to IDLE on the next edge and clear done; done SHALL be high for exactly one cycle.
REQ-017 Result SHALL be exact for all operand pairs; no overflow is possible (e.g. -8*-8=64, -8*7=-56 at WIDTH=4).
REQ-018 y SHALL hold its last result until the next done pulse; y SHALL NOT change during RUN.
REQ-019 start SHALL be ignored in RUN and DONE; a new multiply can be accepted no earlier than the first cycle back in IDLE (throughput one result per WIDTH+2 cycles).
REQ-020 Changes to a or b after capture SHALL NOT affect the result in progress.
REQ-021 Operand values SHALL be interpreted as signed; a zero operand SHALL yield y=0.

Reset
REQ-022 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE, busy=0, done=0, y=0, and clear the counter and internal registers.
REQ-023 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release, the block SHALL accept start normally.
REQ-024 While rst_n=0, start SHALL be ignored.

Verification
REQ-025 a=3, b=5, start pulse -> busy for 4 cycles, then done pulse with y=15.
REQ-026 a=-7, b=4 -> y=-28 (8'hE4); a=-8, b=-8 -> y=64; a=7, b=-8 -> y=-56.
REQ-027 a=0, b=-5 -> y=0 with done pulse; back-to-back starts held high -> one result per 6 cycles, start ignored while busy.
REQ-028 Change a, b during RUN -> result reflects captured operands only.
REQ-029 Drop rst_n two cycles into RUN -> busy, done, y go to 0 immediately with no done pulse; next start after release completes correctly.
REQ-030 Exhaustive sweep of all 256 (a,b) pairs at WIDTH=4 -> y equals signed a*b for every pair.

Source files
------------

// File: rtl/mul_if.sv
// Handshake and operand/result bundle between a multiply requester and the mul block.
interface mul_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   y;

  modport master (output start, output a, output b, input busy, input done, input y);
  modport slave  (input start, input a, input b, output busy, output done, output y);
endinterface

// File: rtl/mul.sv
// Sequential signed multiplier: one radix-2 Booth step per clock, WIDTH steps per product.
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one Booth add/sub + arithmetic shift per cycle, WIDTH cycles
// DONE  | result on y, done high for this single cycle
module mul #(
  parameter int WIDTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  mul_if.slave   bus
);
  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_cnt;
  logic signed [WIDTH:0]     r_mcand;
  logic signed [WIDTH:0]     r_hi;
  logic [WIDTH-1:0]          r_lo;
  logic                      r_q;
  logic                      r_busy;
  logic                      r_done;
  logic [2*WIDTH-1:0]        r_y;

  logic signed [WIDTH:0]     w_sum;
  logic signed [WIDTH:0]     w_hi_nxt;
  logic [WIDTH-1:0]          w_lo_nxt;

  // Accumulator is WIDTH+1 bits so subtracting the most negative multiplicand cannot overflow.
  always_comb begin
    w_sum = r_hi;
    case ({r_lo[0], r_q})
      2'b01:   w_sum = r_hi + r_mcand;
      2'b10:   w_sum = r_hi - r_mcand;
      default: w_sum = r_hi;
    endcase
  end

  assign w_hi_nxt = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_q     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_y     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mcand <= {bus.a[WIDTH-1], bus.a};
            r_hi    <= '0;
            r_lo    <= bus.b;
            r_q     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_q   <= r_lo[0];
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_y     <= {w_hi_nxt[WIDTH-1:0], w_lo_nxt};
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.y    = r_y;
endmodule

// File: tb/tb_mul.sv
// Self-checking bench for mul: directed vector table, hand sequences, random and exhaustive sweeps.
module tb_mul;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [2*W-1:0] last_y;

  mul_if #(.WIDTH(W)) bus ();

  mul #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] y;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] z);
    int ix;
    int iz;
    ix = $signed(x);
    iz = $signed(z);
    return (2*W)'(ix * iz);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_mul(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [2*W-1:0] exp, input bit scramble, input string nm);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      chk({nm, " busy"}, 32'(bus.busy), 32'd1);
      chk({nm, " y_hold"}, 32'(bus.y), 32'(last_y));
      if (scramble) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    chk({nm, " latency"}, 32'(cyc), 32'(W));
    chk({nm, " y"}, 32'(bus.y), 32'(exp));
    chk({nm, " busy_at_done"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk({nm, " done_width"}, 32'(bus.done), 32'd0);
    chk({nm, " y_after"}, 32'(bus.y), 32'(exp));
    last_y = exp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cyc[$];
    int cyc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    checks = 0;
    errors = 0;
    last_y = '0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    vecs[0] = '{4'd3, 4'd5, 8'd15};
    vecs[1] = '{4'h9, 4'd4, 8'hE4};
    vecs[2] = '{4'h8, 4'h8, 8'h40};
    vecs[3] = '{4'd7, 4'h8, 8'hC8};
    vecs[4] = '{4'd0, 4'hB, 8'h00};
    vecs[5] = '{4'h8, 4'd7, 8'hC8};
    vecs[6] = '{4'hF, 4'hF, 8'h01};
    vecs[7] = '{4'h8, 4'd1, 8'hF8};

    // Reset state, with start held high to show it is ignored during reset
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset y", 32'(bus.y), 32'd0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle busy", 32'(bus.busy), 32'd0);

    foreach (vecs[i]) do_mul(vecs[i].a, vecs[i].b, vecs[i].y, 1'b0, $sformatf("vec%0d", i));

    // Operands wiggled every RUN cycle must not disturb the captured ones
    do_mul(4'd6, 4'hD, ref_mul(4'd6, 4'hD), 1'b1, "scramble");

    // start held high: one result per W+2 cycles
    @(negedge clk);
    bus.a = 4'd2;
    bus.b = 4'd3;
    bus.start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) done_cyc.push_back(i);
    end
    bus.start = 1'b0;
    chk("b2b pulses", 32'(done_cyc.size()), 32'd3);
    for (int i = 1; i < done_cyc.size(); i++)
      chk("b2b spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'(W + 2));
    chk("b2b y", 32'(bus.y), 32'(ref_mul(4'd2, 4'd3)));
    cyc = 0;
    while ((bus.busy || bus.done) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b drain", 32'(bus.busy | bus.done), 32'd0);
    @(negedge clk);
    last_y = ref_mul(4'd2, 4'd3);

    // Reset two cycles into RUN: outputs clear without waiting for clk
    bus.a = 4'd5;
    bus.b = 4'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre-abort busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    chk("abort y", 32'(bus.y), 32'd0);
    bus.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("in-reset done", 32'(bus.done | bus.busy), 32'd0);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    last_y = '0;
    do_mul(4'd5, 4'hD, ref_mul(4'd5, 4'hD), 1'b0, "post-reset");

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_mul(ra, rb, ref_mul(ra, rb), ($urandom_range(0, 1) == 1), "random");
    end

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        do_mul(W'(i), W'(j), ref_mul(W'(i), W'(j)), 1'b0, $sformatf("sweep %0d*%0d", i, j));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
